// File: rtl/timer_seq_pkg.sv
// ============================================================================
// Module   : timer_seq_pkg
// Brief    : Shared FSM encoding, register maps and FIFO entry width.
// Revision : 1.0
// ============================================================================
`default_nettype none

package timer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_HI  = 3'd1,
        ST_WR_MID = 3'd2,
        ST_WR_LO  = 3'd3,
        ST_WR_EN  = 3'd4,
        ST_PLAY   = 3'd5,
        ST_STOP   = 3'd6
    } seq_state_t;

    localparam logic [3:0] c_host_per_hi  = 4'h0;
    localparam logic [3:0] c_host_per_mid = 4'h1;
    localparam logic [3:0] c_host_per_lo  = 4'h2;
    localparam logic [3:0] c_host_dur_hi  = 4'h3;
    localparam logic [3:0] c_host_dur_lo  = 4'h4;
    localparam logic [3:0] c_host_push    = 4'h5;
    localparam logic [3:0] c_host_ctrl    = 4'h6;

    localparam logic [3:0] c_tmr_per_hi   = 4'h0;
    localparam logic [3:0] c_tmr_per_mid  = 4'h1;
    localparam logic [3:0] c_tmr_per_lo   = 4'h2;
    localparam logic [3:0] c_tmr_enable   = 4'h3;

    // Entry layout: {period[23:0], duration[15:0]}
    localparam int c_entry_w = 40;

endpackage

`default_nettype wire

// File: rtl/seq_fifo.sv
// ============================================================================
// Module   : seq_fifo
// Brief    : Synchronous FIFO with flush; push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_pinc  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_pinc;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pinc;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_sequencer.sv
// ============================================================================
// Module   : timer_sequencer
// Brief    : Plays queued {period, duration} notes by programming an external
//            timer through its byte-wide register interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 100000
) (
    input  logic       CORE_CLK,
    input  logic       RST,
    input  logic [3:0] HOST_ADDRESS,
    input  logic [7:0] HOST_DATA_IN,
    input  logic       HOST_STROBE_WR,
    output logic [7:0] HOST_DATA_OUT,
    output logic [3:0] TMR_ADDRESS,
    output logic [7:0] TMR_DATA,
    output logic       TMR_STROBE_WR,
    output logic       BUSY
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICK_DIV - 1);

    seq_state_t           r_state;
    seq_state_t           w_next_state;
    logic [23:0]          r_stage_period;
    logic [15:0]          r_stage_dur;
    logic [23:0]          r_cur_period;
    logic [15:0]          r_cur_dur;
    logic                 r_run;
    logic                 r_overflow;
    logic [PRESC_W-1:0]   r_presc;
    logic [15:0]          r_dur_cnt;

    logic                 w_flush;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [c_entry_w-1:0] w_fifo_rd;
    logic                 w_play_done;
    logic                 w_next_ready;
    logic [7:0]           w_cnt_ext;
    logic [2:0]           w_cnt_disp;

    assign w_flush      = HOST_STROBE_WR && (HOST_ADDRESS == c_host_ctrl) && HOST_DATA_IN[1];
    assign w_push       = HOST_STROBE_WR && (HOST_ADDRESS == c_host_push) && !w_flush;
    assign w_play_done  = (r_presc == '0) && (r_dur_cnt == 16'd1);
    assign w_next_ready = r_run && !w_fifo_empty && !w_flush;

    seq_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CORE_CLK),
        .rst       (RST),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data ({r_stage_period, r_stage_dur}),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_cnt_ext     = 8'(w_fifo_count);
    assign w_cnt_disp    = (w_cnt_ext > 8'd7) ? 3'd7 : w_cnt_ext[2:0];
    assign BUSY          = (r_state != ST_IDLE);
    assign HOST_DATA_OUT = {r_run, BUSY, w_fifo_full, w_fifo_empty, r_overflow, w_cnt_disp};

    always_ff @(posedge CORE_CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A flush lets the current timer write cycle finish, then diverts to STOP.
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        TMR_STROBE_WR = 1'b0;
        TMR_ADDRESS   = 4'h0;
        TMR_DATA      = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_next_ready) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                TMR_STROBE_WR = 1'b1;
                TMR_ADDRESS   = c_tmr_per_hi;
                TMR_DATA      = r_cur_period[23:16];
                w_next_state  = w_flush ? ST_STOP : ST_WR_MID;
            end
            ST_WR_MID: begin
                TMR_STROBE_WR = 1'b1;
                TMR_ADDRESS   = c_tmr_per_mid;
                TMR_DATA      = r_cur_period[15:8];
                w_next_state  = w_flush ? ST_STOP : ST_WR_LO;
            end
            ST_WR_LO: begin
                TMR_STROBE_WR = 1'b1;
                TMR_ADDRESS   = c_tmr_per_lo;
                TMR_DATA      = r_cur_period[7:0];
                w_next_state  = w_flush ? ST_STOP : ST_WR_EN;
            end
            ST_WR_EN: begin
                TMR_STROBE_WR = 1'b1;
                TMR_ADDRESS   = c_tmr_enable;
                TMR_DATA      = (r_cur_period != 24'd0) ? 8'h01 : 8'h00;
                w_next_state  = w_flush ? ST_STOP : ST_PLAY;
            end
            ST_PLAY: begin
                if (w_flush) begin
                    w_next_state = ST_STOP;
                end else if (w_play_done) begin
                    if (w_next_ready) begin
                        w_pop        = 1'b1;
                        w_next_state = ST_WR_HI;
                    end else begin
                        w_next_state = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                TMR_STROBE_WR = 1'b1;
                TMR_ADDRESS   = c_tmr_enable;
                TMR_DATA      = 8'h00;
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CORE_CLK) begin
        if (RST) begin
            r_stage_period <= '0;
            r_stage_dur    <= '0;
            r_cur_period   <= '0;
            r_cur_dur      <= '0;
            r_run          <= 1'b0;
            r_overflow     <= 1'b0;
            r_presc        <= '0;
            r_dur_cnt      <= '0;
        end else begin
            if (HOST_STROBE_WR) begin
                case (HOST_ADDRESS)
                    c_host_per_hi:  r_stage_period[23:16] <= HOST_DATA_IN;
                    c_host_per_mid: r_stage_period[15:8]  <= HOST_DATA_IN;
                    c_host_per_lo:  r_stage_period[7:0]   <= HOST_DATA_IN;
                    c_host_dur_hi:  r_stage_dur[15:8]     <= HOST_DATA_IN;
                    c_host_dur_lo:  r_stage_dur[7:0]      <= HOST_DATA_IN;
                    c_host_ctrl:    r_run                 <= HOST_DATA_IN[0];
                    default: ;
                endcase
            end
            if (w_flush) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                {r_cur_period, r_cur_dur} <= w_fifo_rd;
            end
            // Counters are loaded during WR_EN so PLAY starts from a fresh count.
            if (r_state == ST_WR_EN) begin
                r_presc   <= c_presc_max;
                r_dur_cnt <= (r_cur_dur == 16'd0) ? 16'd1 : r_cur_dur;
            end else if (r_state == ST_PLAY) begin
                if (r_presc == '0) begin
                    r_presc   <= c_presc_max;
                    r_dur_cnt <= r_dur_cnt - 16'd1;
                end else begin
                    r_presc <= r_presc - PRESC_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_sequencer.sv
// ============================================================================
// Module   : tb_timer_sequencer
// Brief    : Directed, table-driven bench for timer_sequencer (TICK_DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_timer_sequencer;

    logic       CORE_CLK;
    logic       RST;
    logic [3:0] HOST_ADDRESS;
    logic [7:0] HOST_DATA_IN;
    logic       HOST_STROBE_WR;
    logic [7:0] HOST_DATA_OUT;
    logic [3:0] TMR_ADDRESS;
    logic [7:0] TMR_DATA;
    logic       TMR_STROBE_WR;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    timer_sequencer #(
        .FIFO_DEPTH (4),
        .TICK_DIV   (4)
    ) dut (
        .CORE_CLK       (CORE_CLK),
        .RST            (RST),
        .HOST_ADDRESS   (HOST_ADDRESS),
        .HOST_DATA_IN   (HOST_DATA_IN),
        .HOST_STROBE_WR (HOST_STROBE_WR),
        .HOST_DATA_OUT  (HOST_DATA_OUT),
        .TMR_ADDRESS    (TMR_ADDRESS),
        .TMR_DATA       (TMR_DATA),
        .TMR_STROBE_WR  (TMR_STROBE_WR),
        .BUSY           (BUSY)
    );

    initial CORE_CLK = 1'b0;
    always #5 CORE_CLK = ~CORE_CLK;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge CORE_CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        HOST_ADDRESS   = a;
        HOST_DATA_IN   = d;
        HOST_STROBE_WR = 1'b1;
        step();
        HOST_STROBE_WR = 1'b0;
        HOST_ADDRESS   = 4'h0;
        HOST_DATA_IN   = 8'h00;
    endtask

    task automatic stage_push(input logic [23:0] p, input logic [15:0] d);
        host_wr(4'h0, p[23:16]);
        host_wr(4'h1, p[15:8]);
        host_wr(4'h2, p[7:0]);
        host_wr(4'h3, d[15:8]);
        host_wr(4'h4, d[7:0]);
        host_wr(4'h5, 8'h00);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!TMR_STROBE_WR && n < 20) begin
            n++;
            step();
        end
        if (!TMR_STROBE_WR) chk({name, "_timeout"}, 32'(n), 32'(0));
    endtask

    task automatic expect_wr(input string name, input logic [3:0] a, input logic [7:0] d);
        chk(name, 32'({TMR_STROBE_WR, TMR_ADDRESS, TMR_DATA}), 32'({1'b1, a, d}));
        step();
    endtask

    task automatic count_play(input string name, input int exp_len);
        int n = 0;
        while (!TMR_STROBE_WR && BUSY && n < 1000) begin
            n++;
            step();
        end
        chk(name, 32'(n), 32'(exp_len));
    endtask

    task automatic run_note(input string name, input logic [23:0] p, input logic [15:0] d,
                            input logic [7:0] en, input int play_len);
        host_wr(4'h6, 8'h00);
        stage_push(p, d);
        host_wr(4'h6, 8'h01);
        wait_strobe(name);
        expect_wr({name, "_hi"},  4'h0, p[23:16]);
        expect_wr({name, "_mid"}, 4'h1, p[15:8]);
        expect_wr({name, "_lo"},  4'h2, p[7:0]);
        expect_wr({name, "_en"},  4'h3, en);
        count_play({name, "_play"}, play_len);
        expect_wr({name, "_stop"}, 4'h3, 8'h00);
        chk({name, "_busy"}, 32'(BUSY), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        HOST_ADDRESS = 4'h0;
        HOST_DATA_IN = 8'h00;
        HOST_STROBE_WR = 1'b0;
        repeat (3) step();
        chk("rst_status", 32'(HOST_DATA_OUT), 32'h10);
        chk("rst_tmr", 32'({TMR_STROBE_WR, TMR_ADDRESS, TMR_DATA}), 32'(0));
        chk("rst_busy", 32'(BUSY), 32'(0));
        RST = 1'b0;
        step();
        chk("post_rst_status", 32'(HOST_DATA_OUT), 32'h10);

        // Host register map, push/overflow/flush, run with an empty queue.
        vecs[0]  = '{4'h0, 8'h12, 8'h10};
        vecs[1]  = '{4'h1, 8'h34, 8'h10};
        vecs[2]  = '{4'h2, 8'h56, 8'h10};
        vecs[3]  = '{4'h4, 8'h01, 8'h10};
        vecs[4]  = '{4'h5, 8'h00, 8'h01};
        vecs[5]  = '{4'h5, 8'h00, 8'h02};
        vecs[6]  = '{4'h5, 8'h00, 8'h03};
        vecs[7]  = '{4'h5, 8'h00, 8'h24};
        vecs[8]  = '{4'h5, 8'h00, 8'h2C};
        vecs[9]  = '{4'h8, 8'hFF, 8'h2C};
        vecs[10] = '{4'h6, 8'h02, 8'h10};
        vecs[11] = '{4'h6, 8'h00, 8'h10};
        vecs[12] = '{4'h6, 8'h01, 8'h90};
        vecs[13] = '{4'h6, 8'h00, 8'h10};
        for (int i = 0; i < 14; i++) begin
            host_wr(vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_status", i), 32'(HOST_DATA_OUT), 32'(vecs[i].exp_status));
            chk($sformatf("vec%0d_nostrobe", i), 32'(TMR_STROBE_WR), 32'(0));
        end

        run_note("basic", 24'h02EA85, 16'd2, 8'h01, 8);
        chk("basic_idle_status", 32'(HOST_DATA_OUT), 32'h90);
        run_note("rest", 24'h000000, 16'd1, 8'h00, 4);
        run_note("dur0", 24'h000777, 16'd0, 8'h01, 4);

        // Two queued notes play back to back without a STOP in between.
        host_wr(4'h6, 8'h00);
        stage_push(24'h001234, 16'd1);
        stage_push(24'h00ABCD, 16'd3);
        host_wr(4'h6, 8'h01);
        wait_strobe("gap");
        expect_wr("gap1_hi",  4'h0, 8'h00);
        expect_wr("gap1_mid", 4'h1, 8'h12);
        expect_wr("gap1_lo",  4'h2, 8'h34);
        expect_wr("gap1_en",  4'h3, 8'h01);
        count_play("gap1_play", 4);
        expect_wr("gap2_hi",  4'h0, 8'h00);
        expect_wr("gap2_mid", 4'h1, 8'hAB);
        expect_wr("gap2_lo",  4'h2, 8'hCD);
        expect_wr("gap2_en",  4'h3, 8'h01);
        count_play("gap2_play", 12);
        expect_wr("gap_stop", 4'h3, 8'h00);
        chk("gap_busy", 32'(BUSY), 32'(0));

        // Flush during a long note aborts straight to STOP.
        host_wr(4'h6, 8'h00);
        stage_push(24'h000100, 16'hFFFF);
        host_wr(4'h6, 8'h01);
        wait_strobe("flush");
        expect_wr("flush_hi",  4'h0, 8'h00);
        expect_wr("flush_mid", 4'h1, 8'h01);
        expect_wr("flush_lo",  4'h2, 8'h00);
        expect_wr("flush_en",  4'h3, 8'h01);
        repeat (5) step();
        chk("flush_in_play", 32'({BUSY, TMR_STROBE_WR}), 32'(2));
        host_wr(4'h6, 8'h02);
        expect_wr("flush_stop", 4'h3, 8'h00);
        chk("flush_busy", 32'(BUSY), 32'(0));
        chk("flush_status", 32'(HOST_DATA_OUT), 32'h10);

        // Reset in the middle of a write burst: no STOP write, clean status.
        stage_push(24'h000100, 16'd2);
        host_wr(4'h6, 8'h01);
        wait_strobe("rstmid");
        expect_wr("rstmid_hi", 4'h0, 8'h00);
        chk("rstmid_mid", 32'({TMR_STROBE_WR, TMR_ADDRESS, TMR_DATA}), 32'({1'b1, 4'h1, 8'h01}));
        RST = 1'b1;
        step();
        chk("rstmid_tmr", 32'({TMR_STROBE_WR, TMR_ADDRESS, TMR_DATA}), 32'(0));
        chk("rstmid_status", 32'(HOST_DATA_OUT), 32'h10);
        chk("rstmid_busy", 32'(BUSY), 32'(0));
        RST = 1'b0;
        begin
            int strobes = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (TMR_STROBE_WR) strobes++;
            end
            chk("rstmid_no_writes", 32'(strobes), 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
